// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - round-robin warp scheduler sequencing fetch, exec, mem and writeback
module warp_scheduler #(
   parameter int NUM_WARPS = 4,
   parameter int PC_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NUM_WARPS-1:0] warp_mask,
   output logic                 fetch_req,
   output logic [PC_WIDTH-1:0]  fetch_pc,
   input  logic                 fetch_ack,
   input  logic                 instr_halt,
   input  logic                 instr_is_mem,
   input  logic                 instr_writes_reg,
   output logic [1:0]           warp_num,
   output logic                 exec_en,
   output logic                 lsu_req,
   input  logic                 lsu_done,
   output logic                 reg_write_en,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_FETCH, S_EXEC, S_MEM, S_WB, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q [NUM_WARPS];
   logic [PC_WIDTH-1:0]  pc_d [NUM_WARPS];
   logic [NUM_WARPS-1:0] active_mask_q, active_mask_d;
   logic [NUM_WARPS-1:0] done_mask_q, done_mask_d;
   logic [1:0]           last_q, last_d;
   logic [1:0]           warp_num_q, warp_num_d;
   logic                 is_mem_q, is_mem_d;
   logic                 writes_reg_q, writes_reg_d;

   logic                 sel_found;
   logic [1:0]           sel_warp;
   logic [1:0]           cand;

   // Round-robin search starting just after the last scheduled warp.
   always_comb begin
      sel_found = 1'b0;
      sel_warp  = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_WARPS; i++) begin
         cand = 2'((int'(last_q) + i) % NUM_WARPS);
         if (!sel_found && active_mask_q[cand] && !done_mask_q[cand]) begin
            sel_found = 1'b1;
            sel_warp  = cand;
         end
      end
   end

   // Next-state and datapath updates for the instruction sequencer.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      active_mask_d = active_mask_q;
      done_mask_d   = done_mask_q;
      last_d        = last_q;
      warp_num_d    = warp_num_q;
      is_mem_d      = is_mem_q;
      writes_reg_d  = writes_reg_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               active_mask_d = warp_mask;
               done_mask_d   = '0;
               for (int w = 0; w < NUM_WARPS; w++) pc_d[w] = '0;
               state_d       = S_SELECT;
            end
         end
         S_SELECT: begin
            if (sel_found) begin
               warp_num_d = sel_warp;
               last_d     = sel_warp;
               state_d    = S_FETCH;
            end else begin
               state_d    = S_DONE;
            end
         end
         S_FETCH: begin
            if (fetch_ack) begin
               is_mem_d     = instr_is_mem;
               writes_reg_d = instr_writes_reg;
               if (instr_halt) begin
                  done_mask_d[warp_num_q] = 1'b1;
                  state_d                 = S_SELECT;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            state_d = is_mem_q ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (lsu_done) state_d = S_WB;
         end
         S_WB: begin
            pc_d[warp_num_q] = pc_q[warp_num_q] + 1'b1;
            state_d          = S_SELECT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset aborts any in-flight instruction immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         for (int w = 0; w < NUM_WARPS; w++) pc_q[w] <= '0;
         active_mask_q <= '0;
         done_mask_q   <= '0;
         last_q        <= 2'(NUM_WARPS - 1);
         warp_num_q    <= '0;
         is_mem_q      <= 1'b0;
         writes_reg_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         active_mask_q <= active_mask_d;
         done_mask_q   <= done_mask_d;
         last_q        <= last_d;
         warp_num_q    <= warp_num_d;
         is_mem_q      <= is_mem_d;
         writes_reg_q  <= writes_reg_d;
      end
   end

   // Outputs decode from registered state so reset clears them without waiting for a clock.
   always_comb begin
      fetch_req    = (state_q == S_FETCH);
      fetch_pc     = pc_q[warp_num_q];
      warp_num     = warp_num_q;
      exec_en      = (state_q == S_EXEC);
      lsu_req      = (state_q == S_MEM);
      reg_write_en = (state_q == S_WB) && writes_reg_q;
      busy         = (state_q != S_IDLE);
      done         = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - self-checking bench for warp_scheduler
module tb_warp_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] warp_mask;
   logic       fetch_req;
   logic [7:0] fetch_pc;
   logic       fetch_ack;
   logic       instr_halt;
   logic       instr_is_mem;
   logic       instr_writes_reg;
   logic [1:0] warp_num;
   logic       exec_en;
   logic       lsu_req;
   logic       lsu_done;
   logic       reg_write_en;
   logic       busy;
   logic       done;

   warp_scheduler #(.NUM_WARPS(4), .PC_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .warp_mask(warp_mask),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ack(fetch_ack),
      .instr_halt(instr_halt), .instr_is_mem(instr_is_mem),
      .instr_writes_reg(instr_writes_reg), .warp_num(warp_num),
      .exec_en(exec_en), .lsu_req(lsu_req), .lsu_done(lsu_done),
      .reg_write_en(reg_write_en), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // scoreboard of expected writebacks: {warp, pc}
   logic [9:0] sb_q [$];

   // reference scheduler state
   logic [1:0] m_last;
   logic [3:0] m_active;
   logic [3:0] m_done;
   int         m_cnt [4];

   // scenario configuration
   int halt_after [4];
   bit cfg_mem;
   int cfg_lsu_delay;
   int cfg_ack_delay;
   bit cfg_wr_alt;
   bit cfg_stray;
   bit cfg_hold_start;
   bit cfg_check_gap;
   int done_cycle;

   function automatic logic [1:0] model_pick(output bit found);
      logic [1:0] c;
      found = 1'b0;
      model_pick = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         c = 2'((int'(m_last) + i) % 4);
         if (!found && m_active[c] && !m_done[c]) begin
            found = 1'b1;
            model_pick = c;
         end
      end
   endfunction

   task automatic clear_inputs();
      start = 0; warp_mask = 0; fetch_ack = 0; instr_halt = 0;
      instr_is_mem = 0; instr_writes_reg = 0; lsu_done = 0;
   endtask

   task automatic set_cfg(input int h0, input int h1, input int h2, input int h3);
      halt_after[0] = h0; halt_after[1] = h1; halt_after[2] = h2; halt_after[3] = h3;
      cfg_mem = 0; cfg_lsu_delay = 1; cfg_ack_delay = 0; cfg_wr_alt = 0;
      cfg_stray = 0; cfg_hold_start = 0; cfg_check_gap = 0;
   endtask

   task automatic run_block(input logic [3:0] mask, input int max_cycles);
      int cyc, fetch_wait, lsu_cnt, lsu_run, exec_since_fetch, last_wb;
      bit prev_lsu, finished, found, wr;
      logic [1:0] ew;
      logic [9:0] exp;
      m_active = mask;
      m_done = 0;
      for (int w = 0; w < 4; w++) m_cnt[w] = 0;
      sb_q.delete();
      @(negedge clk);
      warp_mask = mask;
      start = 1;
      cyc = 0; finished = 0; fetch_wait = 0; lsu_cnt = 0; lsu_run = 0;
      exec_since_fetch = 0; last_wb = -1; prev_lsu = 0; done_cycle = -1;
      while (!finished && cyc < max_cycles) begin
         @(negedge clk);
         cyc++;
         if (cfg_hold_start) warp_mask = ~mask; else start = 0;
         fetch_ack = 0; instr_halt = 0; instr_is_mem = 0; instr_writes_reg = 0; lsu_done = 0;
         if (exec_en) exec_since_fetch++;
         if (reg_write_en) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL wb_unexpected: warp=%0d pc=%0d, no writeback expected", warp_num, fetch_pc);
            end else begin
               exp = sb_q.pop_front();
               if ({warp_num, fetch_pc} !== exp) begin
                  bad++;
                  $display("FAIL wb_target: got warp=%0d pc=%0d, want warp=%0d pc=%0d",
                           warp_num, fetch_pc, exp[9:8], exp[7:0]);
               end
            end
            total++;
            if (exec_since_fetch !== 1) begin
               bad++;
               $display("FAIL exec_pulses: got %0d exec_en pulses, want 1", exec_since_fetch);
            end
            if (cfg_mem) begin
               total++;
               if (!prev_lsu || lsu_run != cfg_lsu_delay) begin
                  bad++;
                  $display("FAIL lsu_len: got lsu_req run %0d (prev=%0b), want %0d", lsu_run, prev_lsu, cfg_lsu_delay);
               end
            end
            if (cfg_check_gap && last_wb >= 0) begin
               total++;
               if (cyc - last_wb != 4) begin
                  bad++;
                  $display("FAIL wb_gap: got %0d cycles, want 4", cyc - last_wb);
               end
            end
            last_wb = cyc;
         end
         if (lsu_req) begin
            lsu_cnt++;
            lsu_run = lsu_cnt;
            if (lsu_cnt == cfg_lsu_delay) lsu_done = 1;
         end else begin
            lsu_cnt = 0;
         end
         prev_lsu = lsu_req;
         if (fetch_req) begin
            if (cfg_stray) lsu_done = 1;
            if (fetch_wait == 0) begin
               ew = model_pick(found);
               total++;
               if (!found || warp_num !== ew || fetch_pc !== 8'(m_cnt[ew])) begin
                  bad++;
                  $display("FAIL fetch_target: got warp=%0d pc=%0d, want warp=%0d pc=%0d (found=%0b)",
                           warp_num, fetch_pc, ew, 8'(m_cnt[ew]), found);
               end
               m_last = ew;
               exec_since_fetch = 0;
            end
            fetch_wait++;
            if (fetch_wait > cfg_ack_delay) begin
               fetch_ack = 1;
               fetch_wait = 0;
               if (m_cnt[m_last] == halt_after[m_last]) begin
                  instr_halt = 1; instr_is_mem = 1; instr_writes_reg = 1;
                  m_done[m_last] = 1'b1;
               end else begin
                  wr = !cfg_wr_alt || (m_cnt[m_last] % 2 == 0);
                  instr_is_mem = cfg_mem;
                  instr_writes_reg = wr;
                  if (wr) sb_q.push_back({m_last, 8'(m_cnt[m_last])});
                  m_cnt[m_last]++;
               end
            end
         end
         if (done) begin
            done_cycle = cyc;
            start = 0;
            finished = 1;
            total++;
            if ((m_active & ~m_done) !== 4'd0 || sb_q.size() != 0) begin
               bad++;
               $display("FAIL done_early: pending warps=%b pending wbs=%0d, want 0000 and 0",
                        m_active & ~m_done, sb_q.size());
            end
         end
      end
      if (!finished) begin
         total++; bad++;
         $display("FAIL timeout: done not seen in %0d cycles", max_cycles);
      end else begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_done: busy=%b done=%b, want 0 0", busy, done);
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 0;
      repeat (3) @(negedge clk);
      total++;
      if ({fetch_req, fetch_pc, warp_num, exec_en, lsu_req, reg_write_en, busy, done} !== 16'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h, want 0",
                  {fetch_req, fetch_pc, warp_num, exec_en, lsu_req, reg_write_en, busy, done});
      end
      reset = 1;
      m_last = 2'd3;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_round_robin();
      set_cfg(3, 3, 3, 3);
      cfg_check_gap = 1;
      run_block(4'b1111, 200);
   endtask

   task automatic test_sparse();
      set_cfg(0, 3, 0, 3);
      run_block(4'b1010, 200);
      set_cfg(0, 0, 1, 0);
      run_block(4'b0100, 50);
   endtask

   task automatic test_mem_stall();
      set_cfg(2, 2, 0, 0);
      cfg_mem = 1; cfg_lsu_delay = 6; cfg_stray = 1; cfg_ack_delay = 2;
      run_block(4'b0011, 300);
   endtask

   task automatic test_empty_start();
      set_cfg(0, 0, 0, 0);
      run_block(4'b0000, 20);
      total++;
      if (done_cycle != 2) begin
         bad++;
         $display("FAIL empty_done_latency: got %0d, want 2", done_cycle);
      end
   endtask

   task automatic test_start_while_busy();
      set_cfg(2, 2, 0, 0);
      cfg_hold_start = 1;
      run_block(4'b0011, 200);
   endtask

   task automatic test_pc_wrap();
      set_cfg(258, 0, 0, 0);
      run_block(4'b0001, 2000);
   endtask

   task automatic test_halting();
      set_cfg(1, 3, 6, 0);
      cfg_wr_alt = 1;
      run_block(4'b0111, 300);
   endtask

   task automatic test_reset_mid_mem();
      bit in_mem;
      in_mem = 0;
      @(negedge clk);
      warp_mask = 4'b0001;
      start = 1;
      for (int i = 0; i < 20 && !in_mem; i++) begin
         @(negedge clk);
         start = 0;
         fetch_ack = 0; instr_is_mem = 0; instr_writes_reg = 0;
         if (lsu_req) in_mem = 1;
         else if (fetch_req) begin
            fetch_ack = 1; instr_is_mem = 1; instr_writes_reg = 1;
         end
      end
      total++;
      if (!in_mem) begin
         bad++;
         $display("FAIL reach_mem: lsu_req=%b, want 1", lsu_req);
      end
      #2 reset = 0;
      #1;
      total++;
      if ({busy, lsu_req, reg_write_en, done} !== 4'b0000) begin
         bad++;
         $display("FAIL async_reset: busy/lsu_req/wb/done=%b, want 0000", {busy, lsu_req, reg_write_en, done});
      end
      clear_inputs();
      @(negedge clk);
      reset = 1;
      m_last = 2'd3;
      @(negedge clk);
      total++;
      if ({busy, warp_num, fetch_pc, reg_write_en} !== 12'd0) begin
         bad++;
         $display("FAIL reset_release: busy=%b warp=%0d pc=%0d wb=%b, want 0 0 0 0",
                  busy, warp_num, fetch_pc, reg_write_en);
      end
      // first warp after reset must be warp 0 again
      set_cfg(1, 0, 0, 0);
      run_block(4'b0001, 50);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_sparse();
      test_mem_stall();
      test_empty_start();
      test_start_while_busy();
      test_pc_wrap();
      test_halting();
      test_reset_mid_mem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Per-compute-unit control stage that drives the threads register file.
- Selects one of up to four 8-thread warps round-robin and sequences it through fetch, execute, optional memory wait and writeback.
- Outputs warp_num and reg_write_en, which index and enable the per-warp register file, and handshakes with the fetcher and the LSU.
- Keeps one 8-bit PC per warp and tracks which warps have halted.

Parameters:
NUM_WARPS, 4, number of warps per block (the warp_num encoding is sized for 4)
PC_WIDTH, 8, width of each per-warp program counter

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  launch block execution; sampled only in IDLE
warp_mask  input  NUM_WARPS  bit w=1 means warp w participates; sampled with start
fetch_req  output  1  request the instruction at fetch_pc
fetch_pc  output  PC_WIDTH  PC of the current warp
fetch_ack  input  1  instruction fetched; the decoded flags below are valid in this cycle
instr_halt  input  1  decoded HALT
instr_is_mem  input  1  decoded LDR/STR
instr_writes_reg  input  1  instruction writes rd
warp_num  output  2  current warp, to the register file
exec_en  output  1  one-cycle pulse: ALU/AGU evaluate for warp_num
lsu_req  output  1  LSU operation in progress request
lsu_done  input  1  LSU finished all 8 lanes
reg_write_en  output  1  one-cycle register file write strobe
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when all masked warps have halted

Behaviour:
- States: IDLE, SELECT, FETCH, EXEC, MEM, WB, DONE. Encoding is free.
- While reset=0 (asynchronous):
  - State goes to IDLE.
  - All PCs are 0; done_mask=0; active_mask=0; last warp=NUM_WARPS-1.
  - Captured flags are 0.
  - All outputs are 0, including warp_num=0 and fetch_pc=0.
- Reset asserted in any state aborts the operation immediately. No partial writeback occurs.
- IDLE: if start=1, latch active_mask=warp_mask, clear done_mask, zero all PCs, then go to SELECT.
- start is ignored in every non-IDLE state.
- SELECT (1 cycle):
  - Search warps last+1, last+2, ... modulo NUM_WARPS for the first warp with active=1 and done=0.
  - If found: set warp_num to that warp, record it as last, go to FETCH.
  - If none found: go to DONE.
  - active_mask=0 reaches DONE via SELECT.
- FETCH:
  - fetch_req=1 and fetch_pc=PC[warp_num], held until fetch_ack=1.
  - An ack in the first cycle of FETCH is legal.
  - On ack, capture is_mem and writes_reg.
  - If instr_halt=1: set done[warp_num], leave PC unchanged, go to SELECT. instr_halt has priority over the other flags.
  - Otherwise go to EXEC.
  - fetch_req drops in the cycle after the ack.
- EXEC (1 cycle): exec_en=1. Go to MEM if is_mem, else to WB.
- MEM:
  - lsu_req=1, held until lsu_done=1, then go to WB.
  - lsu_done in the first MEM cycle is legal.
  - lsu_done in any other state is ignored.
- WB (1 cycle):
  - reg_write_en = captured writes_reg.
  - PC[warp_num] <= PC[warp_num]+1, wrapping 255 -> 0 with no flag.
  - Go to SELECT.
- DONE (1 cycle): done=1, busy=1, then go to IDLE. busy=0 from the next cycle.
- warp_num is stable from SELECT exit through WB. The register file may therefore use it combinationally.
- Latencies:
  - Non-memory instruction with 0-wait fetch: SELECT -> FETCH -> EXEC -> WB = 4 cycles.
  - Memory instruction: 5 cycles plus LSU wait.
- One instruction is in flight at a time. There is no overlap between warps.

Test Plan:
- Reset dominance: reset=0 mid-MEM with lsu_req=1 -> busy, lsu_req, reg_write_en, done all 0 in the same cycle (asynchronous). After release, IDLE with warp_num=0.
- Round robin, mask 4'b1111, ALU ops (writes_reg=1, fetch_ack immediate):
  - warp_num sequence is 0,1,2,3,0,...
  - Exactly one reg_write_en per instruction, each 4 cycles apart.
  - PC[w] increments by 1 per visit.
- Sparse mask 4'b1010: only warps 1 and 3 are scheduled, alternating. Warp 2 with HALT at PC=1 under mask 4'b0100 -> PC 0 executes, then done pulses once and busy falls the next cycle.
- Memory stall: is_mem=1, lsu_done after 6 cycles -> lsu_req high for exactly 6 cycles, exec_en a single pulse before it, reg_write_en 1 cycle after lsu_done. Stray lsu_done pulses in FETCH are ignored.
- Empty and illegal start: start with warp_mask=0 -> SELECT, DONE, IDLE; done pulses 2 cycles after start. start=1 while busy -> no effect on the sequence.
- PC wrap: a warp runs 256 non-halt instructions -> fetch_pc goes 255 -> 0. Halting warps: warps 0 and 1 halt at different times -> the remaining warp keeps being selected alone until it halts, then done pulses.
